// File: rtl/vga_capture.sv
// vga_capture: rebuilds VGA position from HS/VS, verifies timing and emits frame-buffer writes; CAPTURE_CRC_EN adds FRAME_CRC
module vga_capture #(
  parameter int HPERIOD = 800,
  parameter int HWIDTH  = 96,
  parameter int HBACK   = 48,
  parameter int HACTIVE = 640,
  parameter int VPERIOD = 525,
  parameter int VWIDTH  = 2,
  parameter int VBACK   = 33,
  parameter int VACTIVE = 480
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  output logic        WE,
  output logic [18:0] WADDR,
  output logic [11:0] WDATA,
  output logic        FRAME_DONE,
  output logic        LOCKED,
`ifdef CAPTURE_CRC_EN
  output logic [15:0] FRAME_CRC,
`endif
  output logic        ERR
);
  localparam logic [1:0] HUNT = 2'd0, CHECK = 2'd1, LOCK = 2'd2;
  localparam logic [10:0] H_LO = 11'(HWIDTH + HBACK);
  localparam logic [10:0] H_HI = 11'(HWIDTH + HBACK + HACTIVE);
  localparam logic [9:0]  V_LO = 10'(VWIDTH + VBACK);
  localparam logic [9:0]  V_HI = 10'(VWIDTH + VBACK + VACTIVE);
  localparam logic [10:0] H_LAST = 11'(HPERIOD - 1);
  localparam logic [9:0]  V_LAST = 10'(VPERIOD - 1);
  localparam logic [18:0] A_LAST = 19'(HACTIVE * VACTIVE - 1);
  logic [3:0]  r_sr, r_sg, r_sb;
  logic        r_shs, r_phs, r_svs, r_line_vs;
  logic [10:0] r_hpos;
  logic [9:0]  r_vline;
  logic [1:0]  r_state;
  logic        r_we, r_done, r_err;
  logic [18:0] r_waddr;
  logic [11:0] r_wdata;
  logic        w_hs_fall, w_fstart, w_active, w_viol, w_we, w_done;
  logic [10:0] w_hpos;
  logic [9:0]  w_vline;
  logic [1:0]  w_next;
  // w_hpos/w_vline are the position of the pixel currently held in r_s*
  always_comb begin
    w_hs_fall = r_phs & ~r_shs;
    w_fstart  = w_hs_fall & r_line_vs & ~r_svs;
    w_hpos    = w_hs_fall ? 11'd0 : (&r_hpos ? r_hpos : r_hpos + 11'd1);
    w_vline   = w_fstart ? 10'd0 : (w_hs_fall && !(&r_vline)) ? r_vline + 10'd1 : r_vline;
    w_active  = (w_hpos >= H_LO) && (w_hpos < H_HI) && (w_vline >= V_LO) && (w_vline < V_HI);
    w_viol    = (r_state != HUNT) &&
                ((w_hs_fall && r_hpos != H_LAST) || (w_fstart && r_vline != V_LAST));
    w_next    = w_viol ? HUNT : w_fstart ? (r_state == HUNT ? CHECK : LOCK) : r_state;
    w_we      = (w_next == LOCK) && w_active;
    w_done    = r_we && (r_waddr == A_LAST) && (w_next == LOCK);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sr      <= '0;
      r_sg      <= '0;
      r_sb      <= '0;
      r_shs     <= 1'b1;
      r_phs     <= 1'b1;
      r_svs     <= 1'b1;
      r_line_vs <= 1'b1;
      r_hpos    <= '0;
      r_vline   <= '0;
      r_state   <= HUNT;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_sr      <= VGA_R;
      r_sg      <= VGA_G;
      r_sb      <= VGA_B;
      r_shs     <= VGA_HS;
      r_phs     <= r_shs;
      r_svs     <= VGA_VS;
      r_line_vs <= w_hs_fall ? r_svs : r_line_vs;
      r_hpos    <= w_hpos;
      r_vline   <= w_vline;
      r_state   <= w_next;
      r_we      <= w_we;
      r_done    <= w_done;
      r_err     <= w_viol;
      r_waddr   <= w_fstart ? 19'd0 : r_we ? r_waddr + 19'd1 : r_waddr;
      r_wdata   <= w_we ? {r_sr, r_sg, r_sb} : r_wdata;
    end
  end
`ifdef CAPTURE_CRC_EN
  logic [15:0] r_crc, r_frame_crc;
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] n;
    n = c;
    for (int i = 11; i >= 0; i--) n = {n[14:0], 1'b0} ^ ((n[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return n;
  endfunction
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_crc       <= 16'hFFFF;
      r_frame_crc <= '0;
    end else begin
      r_crc       <= w_fstart ? 16'hFFFF : r_we ? crc12(r_crc, r_wdata) : r_crc;
      r_frame_crc <= w_done ? crc12(r_crc, r_wdata) : r_frame_crc;
    end
  end
  assign FRAME_CRC = r_frame_crc;
`endif
  assign WE         = r_we;
  assign WADDR      = r_waddr;
  assign WDATA      = r_wdata;
  assign FRAME_DONE = r_done;
  assign LOCKED     = (r_state == LOCK);
  assign ERR        = r_err;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frame sequences on a scaled-down raster checking lock, mapping, faults and reset
module tb_vga_capture;
  localparam int HP = 20, HW = 2, HB = 3, HA = 8;
  localparam int VP = 10, VW = 1, VB = 2, VA = 4;
  localparam int HS0 = HW + HB, VS0 = VW + VB;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic        VGA_HS = 1'b1, VGA_VS = 1'b1;
  logic        WE, FRAME_DONE, LOCKED, ERR;
  logic [18:0] WADDR;
  logic [11:0] WDATA;
`ifdef CAPTURE_CRC_EN
  logic [15:0] FRAME_CRC;
`endif
  int n_cmp = 0, n_bad = 0, n_we = 0, n_done = 0, n_err = 0;
  logic        pv_we = 1'b0, p_act = 1'b0;
  logic [18:0] pv_addr = '0, p_addr = '0;
  logic [11:0] p_data = '0;
  logic [15:0] b_crc = 16'hFFFF;

  vga_capture #(
    .HPERIOD(HP), .HWIDTH(HW), .HBACK(HB), .HACTIVE(HA),
    .VPERIOD(VP), .VWIDTH(VW), .VBACK(VB), .VACTIVE(VA)
  ) dut (
    .CLK(CLK), .RST(RST),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED),
`ifdef CAPTURE_CRC_EN
    .FRAME_CRC(FRAME_CRC),
`endif
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] n;
    n = c;
    for (int i = 11; i >= 0; i--) begin
      if (n[15] ^ d[i]) n = (n << 1) ^ 16'h1021;
      else n = n << 1;
    end
    return n;
  endfunction

  // drive pixel (h,v), then look at what the DUT produced for the previous pixel
  task automatic tick(input int h, input int v, input bit zero);
    int x, y;
    bit act;
    logic [11:0] px;
    x = h - HS0;
    y = v - VS0;
    act = (h >= HS0) && (h < HS0 + HA) && (v >= VS0) && (v < VS0 + VA);
    px = zero ? 12'h000 : act ? {x[3:0], y[3:0], x[7:4]} : 12'h5A5;
    {VGA_R, VGA_G, VGA_B} = px;
    VGA_HS = (h >= HW);
    VGA_VS = (v >= VW);
    if (act) b_crc = crc_ref(b_crc, px);
    @(posedge CLK);
    #1;
    if (WE) begin
      n_we++;
      check("we_in_window", 64'(p_act), 64'd1);
      check("waddr", 64'(WADDR), 64'(p_addr));
      check("wdata", 64'(WDATA), 64'(p_data));
    end
    if (FRAME_DONE) begin
      n_done++;
      check("done_after_last", 64'({pv_we, pv_addr}), 64'({1'b1, 19'(HA * VA - 1)}));
`ifdef CAPTURE_CRC_EN
      check("frame_crc", 64'(FRAME_CRC), 64'(b_crc));
`endif
    end
    if (ERR) begin
      n_err++;
      check("err_drops_lock", 64'(LOCKED), 64'd0);
    end
    pv_we = WE;
    pv_addr = WADDR;
    p_act = act;
    p_addr = 19'(y * HA + x);
    p_data = px;
  endtask

  task automatic run_frame(input int sv, input int rv, input bit zero, input int e_we,
                           input int e_done, input int e_err, input logic e_lock, input string tag);
    n_we = 0;
    n_done = 0;
    n_err = 0;
    b_crc = 16'hFFFF;
    for (int v = 0; v < VP; v++) begin
      for (int h = 0; h < HP + ((v == sv) ? 1 : 0); h++) begin
        if (v == rv && h == 8) begin
          RST = 1'b0;
          #1;
          check({tag, "_rst_flags"}, 64'({WE, FRAME_DONE, LOCKED, ERR, WDATA}), 64'd0);
          check({tag, "_rst_waddr"}, 64'(WADDR), 64'd0);
        end
        if (v == rv && h == 12) RST = 1'b1;
        tick(h, v, zero);
      end
    end
    check({tag, "_we_count"}, 64'(n_we), 64'(e_we));
    check({tag, "_done_count"}, 64'(n_done), 64'(e_done));
    check({tag, "_err_count"}, 64'(n_err), 64'(e_err));
    check({tag, "_locked"}, 64'(LOCKED), 64'(e_lock));
  endtask

  initial begin
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick((i % 2 != 0) ? 0 : 10, ((i / 2) % 2 != 0) ? 0 : 5, 1'b0);
      check("reset_flags", 64'({WE, FRAME_DONE, LOCKED, ERR, WDATA}), 64'd0);
      check("reset_waddr", 64'(WADDR), 64'd0);
    end
    RST = 1'b1;
    for (int i = 0; i < 3; i++) tick(15, 9, 1'b0);
    run_frame(-1, -1, 1'b0, 0, 0, 0, 1'b0, "f1_hunt");
    run_frame(-1, -1, 1'b0, HA * VA, 1, 0, 1'b1, "f2_grad");
    run_frame(-1, -1, 1'b1, HA * VA, 1, 0, 1'b1, "f3_zero");
    run_frame(4, -1, 1'b0, 2 * HA, 0, 1, 1'b0, "f4_stretch");
    run_frame(-1, -1, 1'b0, 0, 0, 0, 1'b0, "f5_recheck");
    run_frame(-1, -1, 1'b0, HA * VA, 1, 0, 1'b1, "f6_relock");
    run_frame(-1, 5, 1'b0, 2 * HA + 2, 0, 0, 1'b0, "f7_midreset");
    run_frame(-1, -1, 1'b0, 0, 0, 0, 1'b0, "f8_recheck");
    run_frame(-1, -1, 1'b0, HA * VA, 1, 0, 1'b1, "f9_relock");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
